// File: rtl/n2_ict_tagvld_array.sv
// n2_ict_tagvld_array: I-cache tag/valid array with tag compare and invalidate-all.
// Optional per-way even parity is built when ICT_PARITY_EN is defined.
module n2_ict_tagvld_array #(
    parameter int NUM_WAYS = 8,
    parameter int IDX_W    = 6,
    parameter int TAG_W    = 29,
    parameter int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic                      l2clk,
    input  logic                      reset,
    input  logic                      clk_en,
    input  logic                      array_wr_inhibit,
    input  logic [IDX_W-1:0]          index_bf,
    input  logic                      rd_req_bf,
    input  logic [TAG_W-1:0]          cmp_tag_bf,
    input  logic                      wr_req_bf,
    input  logic [WAY_W-1:0]          wr_way_bf,
    input  logic [TAG_W-1:0]          wr_tag_bf,
    input  logic                      inv_req_bf,
    input  logic                      inv_all_req,
    output logic [NUM_WAYS*TAG_W-1:0] way_tag_f,
    output logic [NUM_WAYS-1:0]       way_vld_f,
    output logic                      rd_vld_f,
    output logic                      hit_f,
    output logic [WAY_W-1:0]          hit_way_f,
    output logic                      multi_hit_f,
    output logic [NUM_WAYS-1:0]       perr_f,
    output logic                      init_busy
);

    localparam int SETS = 1 << IDX_W;
`ifdef ICT_PARITY_EN
    localparam int MW = TAG_W + 1;
`else
    localparam int MW = TAG_W;
`endif

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               cnt_q, cnt_d;
    logic                           wr_acc, inv_acc, rd_acc;

    logic [MW-1:0]                  tag_mem [SETS][NUM_WAYS];
    logic [SETS-1:0][NUM_WAYS-1:0]  vld_q;

    logic [MW-1:0]                  tag_f_q [NUM_WAYS];
    logic [NUM_WAYS-1:0]            vld_f_q;
    logic [TAG_W-1:0]               cmp_q;
    logic                           rd_vld_q;

    logic [NUM_WAYS-1:0]            match;
    logic [NUM_WAYS-1:0]            perr;
    logic [WAY_W-1:0]               hit_way;
    logic [MW-1:0]                  wr_entry;

    // FSM state and init counter register
    always_ff @(posedge l2clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state, init sweep and request arbitration (write > inv > read)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_acc  = 1'b0;
        inv_acc = 1'b0;
        rd_acc  = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (inv_all_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else if (clk_en && !reset) begin
                    if (wr_req_bf) begin
                        wr_acc = 1'b1;
                    end else if (inv_req_bf) begin
                        inv_acc = 1'b1;
                    end else if (rd_req_bf) begin
                        rd_acc = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign init_busy = (state_q == ST_INIT);

    // stored entry: tag plus even-parity bit when enabled
`ifdef ICT_PARITY_EN
    assign wr_entry = {^wr_tag_bf, wr_tag_bf};
`else
    assign wr_entry = wr_tag_bf;
`endif

    // tag storage; deliberately not reset
    always_ff @(posedge l2clk) begin
        if (wr_acc && !array_wr_inhibit) begin
            tag_mem[index_bf][wr_way_bf] <= wr_entry;
        end
    end

    // valid bits: init sweep clears one set per cycle, fills set, inv clears
    always_ff @(posedge l2clk) begin
        if (state_q == ST_INIT) begin
            vld_q[cnt_q] <= '0;
        end else if (wr_acc && !array_wr_inhibit) begin
            vld_q[index_bf][wr_way_bf] <= 1'b1;
        end else if (inv_acc && !array_wr_inhibit) begin
            vld_q[index_bf][wr_way_bf] <= 1'b0;
        end
    end

    // f-stage read registers; hold when no read is accepted
    always_ff @(posedge l2clk) begin
        if (reset) begin
            rd_vld_q <= 1'b0;
            vld_f_q  <= '0;
            cmp_q    <= '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                tag_f_q[w] <= '0;
            end
        end else begin
            rd_vld_q <= rd_acc;
            if (rd_acc) begin
                vld_f_q <= vld_q[index_bf];
                cmp_q   <= cmp_tag_bf;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    tag_f_q[w] <= tag_mem[index_bf][w];
                end
            end
        end
    end

    // per-way parity check and tag compare on registered data
    always_comb begin
        perr  = '0;
        match = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
`ifdef ICT_PARITY_EN
            perr[w] = vld_f_q[w] & (^tag_f_q[w]);
`endif
            match[w] = vld_f_q[w] & ~perr[w]
                     & (tag_f_q[w][TAG_W-1:0] == cmp_q);
        end
    end

    // lowest matching way wins
    always_comb begin
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                hit_way = WAY_W'(w);
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_WAYS; g++) begin : g_tag_out
            assign way_tag_f[g*TAG_W +: TAG_W] = tag_f_q[g][TAG_W-1:0];
        end
    endgenerate

    assign way_vld_f   = vld_f_q;
    assign rd_vld_f    = rd_vld_q;
    assign hit_f       = |match;
    assign hit_way_f   = hit_way;
    assign multi_hit_f = |(match & (match - NUM_WAYS'(1)));
    assign perr_f      = perr;

endmodule

// File: tb/tb_n2_ict_tagvld_array.sv
// Directed bench for n2_ict_tagvld_array (default 8 ways, 64 sets, 29-bit tags).
// Parity checks are built only when ICT_PARITY_EN is defined.
module tb_n2_ict_tagvld_array;

    localparam int NW = 8;
    localparam int IW = 6;
    localparam int TW = 29;
    localparam int WW = 3;

    logic            l2clk = 1'b0;
    logic            reset;
    logic            clk_en;
    logic            array_wr_inhibit;
    logic [IW-1:0]   index_bf;
    logic            rd_req_bf;
    logic [TW-1:0]   cmp_tag_bf;
    logic            wr_req_bf;
    logic [WW-1:0]   wr_way_bf;
    logic [TW-1:0]   wr_tag_bf;
    logic            inv_req_bf;
    logic            inv_all_req;
    logic [NW*TW-1:0] way_tag_f;
    logic [NW-1:0]   way_vld_f;
    logic            rd_vld_f;
    logic            hit_f;
    logic [WW-1:0]   hit_way_f;
    logic            multi_hit_f;
    logic [NW-1:0]   perr_f;
    logic            init_busy;

    int compared = 0;
    int mismatched = 0;
    int n;

    n2_ict_tagvld_array dut (
        .l2clk            (l2clk),
        .reset            (reset),
        .clk_en           (clk_en),
        .array_wr_inhibit (array_wr_inhibit),
        .index_bf         (index_bf),
        .rd_req_bf        (rd_req_bf),
        .cmp_tag_bf       (cmp_tag_bf),
        .wr_req_bf        (wr_req_bf),
        .wr_way_bf        (wr_way_bf),
        .wr_tag_bf        (wr_tag_bf),
        .inv_req_bf       (inv_req_bf),
        .inv_all_req      (inv_all_req),
        .way_tag_f        (way_tag_f),
        .way_vld_f        (way_vld_f),
        .rd_vld_f         (rd_vld_f),
        .hit_f            (hit_f),
        .hit_way_f        (hit_way_f),
        .multi_hit_f      (multi_hit_f),
        .perr_f           (perr_f),
        .init_busy        (init_busy)
    );

    always #5 l2clk = ~l2clk;

    task automatic tick();
        @(posedge l2clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_wr(input logic [IW-1:0] idx, input logic [WW-1:0] way,
                         input logic [TW-1:0] tag);
        index_bf = idx; wr_way_bf = way; wr_tag_bf = tag; wr_req_bf = 1'b1;
        tick();
        wr_req_bf = 1'b0;
    endtask

    task automatic do_inv(input logic [IW-1:0] idx, input logic [WW-1:0] way);
        index_bf = idx; wr_way_bf = way; inv_req_bf = 1'b1;
        tick();
        inv_req_bf = 1'b0;
    endtask

    task automatic do_rd(input logic [IW-1:0] idx, input logic [TW-1:0] cmp);
        index_bf = idx; cmp_tag_bf = cmp; rd_req_bf = 1'b1;
        tick();
        rd_req_bf = 1'b0;
    endtask

    // counts cycles with init_busy high, including the current sample
    task automatic count_busy(output int cnt);
        cnt = init_busy ? 1 : 0;
        while (init_busy && cnt < 200) begin
            tick();
            if (init_busy) cnt++;
        end
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b1; array_wr_inhibit = 1'b0;
        index_bf = '0; rd_req_bf = 1'b0; cmp_tag_bf = '0;
        wr_req_bf = 1'b0; wr_way_bf = '0; wr_tag_bf = '0;
        inv_req_bf = 1'b0; inv_all_req = 1'b0;

        tick();
        tick();
        chk("rst_rd_vld", 64'(rd_vld_f), 64'd0);
        chk("rst_way_vld", 64'(way_vld_f), 64'd0);
        chk("rst_hit", 64'(hit_f), 64'd0);
        chk("rst_hit_way", 64'(hit_way_f), 64'd0);
        chk("rst_multi", 64'(multi_hit_f), 64'd0);
        chk("rst_perr", 64'(perr_f), 64'd0);
        chk("rst_tag5", 64'(way_tag_f[5*TW +: TW]), 64'd0);
        chk("rst_busy", 64'(init_busy), 64'd1);

        // read during init is dropped
        reset = 1'b0;
        do_rd(6'd0, '0);
        chk("init_rd_drop", 64'(rd_vld_f), 64'd0);
        n = 1;
        while (init_busy && n < 200) begin
            tick();
            if (init_busy) n++;
        end
        n++;
        chk("init_len", 64'(n), 64'd64);
        chk("idle_busy", 64'(init_busy), 64'd0);

        do_rd(6'd63, '0);
        chk("r63_rd_vld", 64'(rd_vld_f), 64'd1);
        chk("r63_vld", 64'(way_vld_f), 64'h00);
        chk("r63_hit", 64'(hit_f), 64'd0);

        // write then read back-to-back
        do_wr(6'd17, 3'd5, 29'h0ABCDEF);
        do_rd(6'd17, 29'h0ABCDEF);
        chk("w17_rd_vld", 64'(rd_vld_f), 64'd1);
        chk("w17_hit", 64'(hit_f), 64'd1);
        chk("w17_way", 64'(hit_way_f), 64'd5);
        chk("w17_vld", 64'(way_vld_f), 64'h20);
        chk("w17_tag", 64'(way_tag_f[5*TW +: TW]), 64'h0ABCDEF);
        chk("w17_perr", 64'(perr_f), 64'h00);

        // no request: f outputs hold, rd_vld drops
        tick();
        chk("hold_rd_vld", 64'(rd_vld_f), 64'd0);
        chk("hold_hit", 64'(hit_f), 64'd1);
        chk("hold_way", 64'(hit_way_f), 64'd5);

        // clk_en low blocks a read
        clk_en = 1'b0;
        do_rd(6'd63, '0);
        clk_en = 1'b1;
        chk("cen_rd_vld", 64'(rd_vld_f), 64'd0);
        chk("cen_vld", 64'(way_vld_f), 64'h20);

        // multi-hit, then invalidate the lower way
        do_wr(6'd3, 3'd2, 29'h1234567);
        do_wr(6'd3, 3'd6, 29'h1234567);
        do_rd(6'd3, 29'h1234567);
        chk("mh_way", 64'(hit_way_f), 64'd2);
        chk("mh_multi", 64'(multi_hit_f), 64'd1);
        chk("mh_vld", 64'(way_vld_f), 64'h44);
        do_inv(6'd3, 3'd2);
        do_rd(6'd3, 29'h1234567);
        chk("inv_way", 64'(hit_way_f), 64'd6);
        chk("inv_multi", 64'(multi_hit_f), 64'd0);
        chk("inv_vld", 64'(way_vld_f), 64'h40);
        chk("inv_tag2", 64'(way_tag_f[2*TW +: TW]), 64'h1234567);

        // tag mismatch
        do_rd(6'd3, 29'h1234566);
        chk("miss_hit", 64'(hit_f), 64'd0);
        chk("miss_way", 64'(hit_way_f), 64'd0);
        chk("miss_tag6", 64'(way_tag_f[6*TW +: TW]), 64'h1234567);

        // inhibit blocks write and invalidate
        array_wr_inhibit = 1'b1;
        do_wr(6'd9, 3'd0, 29'h0000111);
        do_inv(6'd17, 3'd5);
        array_wr_inhibit = 1'b0;
        do_rd(6'd9, 29'h0000111);
        chk("inh_wr_vld", 64'(way_vld_f), 64'h00);
        chk("inh_wr_hit", 64'(hit_f), 64'd0);
        do_rd(6'd17, 29'h0ABCDEF);
        chk("inh_inv_vld", 64'(way_vld_f), 64'h20);

        // write beats read
        rd_req_bf = 1'b1;
        cmp_tag_bf = 29'h55;
        do_wr(6'd9, 3'd1, 29'h55);
        rd_req_bf = 1'b0;
        chk("wr_rd_drop", 64'(rd_vld_f), 64'd0);
        do_rd(6'd9, 29'h55);
        chk("wr_rd_way", 64'(hit_way_f), 64'd1);
        chk("wr_rd_vld", 64'(way_vld_f), 64'h02);

        // invalidate beats read
        rd_req_bf = 1'b1;
        do_inv(6'd9, 3'd1);
        rd_req_bf = 1'b0;
        chk("inv_rd_drop", 64'(rd_vld_f), 64'd0);
        do_rd(6'd9, 29'h55);
        chk("inv_rd_vld", 64'(way_vld_f), 64'h00);

        // invalidate-all, reset at count 30
        do_wr(6'd9, 3'd7, 29'h77);
        do_wr(6'd40, 3'd0, 29'h40);
        inv_all_req = 1'b1;
        tick();
        inv_all_req = 1'b0;
        chk("ia_busy", 64'(init_busy), 64'd1);
        do_rd(6'd40, 29'h40);
        chk("ia_rd_drop", 64'(rd_vld_f), 64'd0);
        for (int i = 0; i < 29; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy(n);
        chk("ia_len", 64'(n), 64'd64);
        do_rd(6'd17, 29'h0ABCDEF);
        chk("ia_v17", 64'(way_vld_f), 64'h00);
        chk("ia_h17", 64'(hit_f), 64'd0);
        do_rd(6'd3, 29'h1234567);
        chk("ia_v3", 64'(way_vld_f), 64'h00);
        do_rd(6'd9, 29'h77);
        chk("ia_v9", 64'(way_vld_f), 64'h00);
        do_rd(6'd40, 29'h40);
        chk("ia_v40", 64'(way_vld_f), 64'h00);
        chk("ia_tag40", 64'(way_tag_f[0 +: TW]), 64'h40);

`ifdef ICT_PARITY_EN
        do_wr(6'd4, 3'd1, 29'h0F0F0F0);
        dut.tag_mem[4][1][0] = ~dut.tag_mem[4][1][0];
        do_rd(6'd4, 29'h0F0F0F1);
        chk("par_perr", 64'(perr_f), 64'h02);
        chk("par_hit", 64'(hit_f), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/n2_ict_tagvld_array.md
# n2_ict_tagvld_array

Parametrised instruction-cache tag array with valid bits, integrated tag compare, optional per-way parity, and a hardware invalidate-all sequencer. It is the behavioural successor to the fixed 8-way, 64-set, 30-bit IFU tag array. Unlike that array, it owns valid state, produces hit/way results itself, and arbitrates read, write and invalidate requests in the bf stage with results in the f stage.

## Interface
Parameters:
- NUM_WAYS, 8, associativity; a power of two, 2..16.
- IDX_W, 6, index width; the array has 2**IDX_W sets.
- TAG_W, 29, tag payload width, excluding parity.
- WAY_W, $clog2(NUM_WAYS), derived; do not override.

Ports (the clock and reset are first; reset is synchronous and active-high):
- l2clk  in  1  block clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- clk_en  in  1  operation enable; when low, no request is accepted and all f outputs hold.
- array_wr_inhibit  in  1  blocks tag writes and single invalidates; reads and the init sequence still run.
- index_bf  in  IDX_W  set index for the bf-stage request.
- rd_req_bf  in  1  read and compare request.
- cmp_tag_bf  in  TAG_W  tag compared against every way.
- wr_req_bf  in  1  tag fill request.
- wr_way_bf  in  WAY_W  way to fill or invalidate.
- wr_tag_bf  in  TAG_W  fill tag.
- inv_req_bf  in  1  clears the valid bit of (index_bf, wr_way_bf).
- inv_all_req  in  1  starts the invalidate-all sequence.
- way_tag_f  out  NUM_WAYS*TAG_W  stored tags; way w occupies [w*TAG_W +: TAG_W].
- way_vld_f  out  NUM_WAYS  valid bits of the set that was read.
- rd_vld_f  out  1  pulses for one cycle when a read completed.
- hit_f  out  1  some valid way matched cmp_tag.
- hit_way_f  out  WAY_W  lowest matching way; 0 when there is no hit.
- multi_hit_f  out  1  more than one valid way matched.
- perr_f  out  NUM_WAYS  per-way parity error on a valid way.
- init_busy  out  1  the invalidate-all sequence is running.

## Operation
- Storage per (set, way): tag[TAG_W], a parity bit (macro-gated), and a valid bit.
- FSM states:
  - INIT: entered on reset, or from IDLE when inv_all_req=1. An IDX_W-bit counter starts at 0. Each cycle the FSM clears all valid bits of set[counter] and increments the counter. After the cycle at set 2**IDX_W-1 it goes to IDLE. init_busy=1 throughout.
  - IDLE: serves bf requests. inv_all_req seen in INIT is ignored.
- Request priority in IDLE with clk_en=1: wr_req_bf, then inv_req_bf, then rd_req_bf. Only one request is accepted per cycle.
- A losing read is dropped. rd_vld_f is then 0 next cycle and the f outputs hold.
- Requests arriving in INIT are dropped without any effect.
- Write: the tag and its parity are stored and the valid bit is set. Suppressed when array_wr_inhibit=1.
- Invalidate: only the valid bit is cleared. Suppressed when array_wr_inhibit=1.
- Read: all ways of the set are read. cmp_tag_bf is registered, and compare runs on the registered data.
  - hit_w = valid_w & (tag_w == cmp_tag).
  - An invalid way never hits. Its tag is still presented.
- With no read accepted, every f output holds its last value, except rd_vld_f, which is 0.

## Timing
- Read latency is 1. A request accepted in cycle N drives every f output in cycle N+1.
- Write to read is 0 bubbles. A read of the same (index, way) in cycle N+1 returns the new tag with valid=1.
- Reset values:
  - way_tag_f, way_vld_f, hit_f, hit_way_f, multi_hit_f, perr_f and rd_vld_f are 0.
  - init_busy is 1 from the first cycle after reset and stays high for 2**IDX_W cycles (64 at default).
- Reset asserted mid-INIT restarts the counter at 0.
- Reset does not clear tags. Only the valid bits are cleared, through INIT.
- Counter wrap: the INIT to IDLE transition happens on the cycle the counter equals all-ones. The counter never wraps into a second pass.

## Configuration
- ICT_PARITY_EN defined:
  - An even-parity bit over the tag is stored on each write.
  - On a read, perr_f[w] = valid_w & (^{tag_w, par_w}).
  - A way with a parity error is excluded from hit_w.
- ICT_PARITY_EN undefined: no parity storage is built, perr_f is tied to 0, and hit uses tag and valid only.

## Test plan
- Reset, then a read of index 0 in cycle 0: init_busy=1 for 64 cycles, the read is dropped (rd_vld_f=0). Reading index 63 after init gives way_vld_f=8'h00 and hit_f=0.
- Write way 5, index 17, tag 29'h0ABCDEF in cycle N, then read index 17 with cmp 29'h0ABCDEF in N+1: in N+2, rd_vld_f=1, hit_f=1, hit_way_f=5, way_vld_f=8'h20.
- Write tag T to ways 2 and 6 of index 3, then read with cmp T: hit_way_f=2, multi_hit_f=1. Invalidate way 2, then read again: hit_way_f=6, multi_hit_f=0.
- Set array_wr_inhibit=1 and write way 0 of index 9: a later read shows way_vld_f[0]=0. Issue rd_req_bf and wr_req_bf together: the write wins and rd_vld_f=0 next cycle.
- Fill several sets, pulse inv_all_req, and assert reset at INIT count 30: init_busy lasts 64 more cycles, then all way_vld_f read as 0.
- ICT_PARITY_EN: force-flip a stored tag bit of way 1 at index 4, then read with a matching cmp: perr_f=8'h02 and hit_f=0.
